// File: rtl/mmu_arbiter_if.sv
// Cache-side and MMU-side line-port signals shared by the arbiter and its neighbours.
interface mmu_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [LINE_W-1:0] i_rdata;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_done;
  logic [LINE_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_done;
  logic [LINE_W-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_done, mem_rdata,
    output i_done, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  // Requester / MMU view
  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_done, mem_rdata,
    input  i_done, i_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mmu_arbiter.sv
// Round-robin arbiter sharing the MMU line port between the L1 I-cache and L1 D-cache.
module mmu_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic            sys_clk,
  input  logic            rst,
  mmu_arbiter_if.slave    bus,
  output logic            arb_busy,
  output logic            arb_owner
);

  localparam int unsigned OFF_W = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state;
  logic              last_owner;
  logic              owner_q;
  logic              we_q;
  logic              mem_req_q;
  logic              i_done_q;
  logic              d_done_q;
  logic              busy_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;

  logic              d_req_c;
  logic              grant_c;
  logic              grant_d_c;
  logic [ADDR_W-1:0] req_addr_c;

  // Grant decision: a lone requester wins; on a tie the one that did not go last wins.
  always_comb begin
    d_req_c    = bus.d_read | bus.d_write;
    grant_c    = bus.i_read | d_req_c;
    grant_d_c  = d_req_c & (~bus.i_read | ~last_owner);
    req_addr_c = grant_d_c ? bus.d_addr : bus.i_addr;
  end

  // Arbitration FSM with registered grant, MMU request and completion pulses.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      mem_req_q  <= 1'b0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      busy_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_c) begin
            owner_q    <= grant_d_c;
            last_owner <= grant_d_c;
            addr_q     <= req_addr_c & ~OFF_MASK;
            we_q       <= grant_d_c & bus.d_write;
            if (grant_d_c && bus.d_write) begin
              wdata_q <= bus.d_wdata;
            end
            mem_req_q  <= 1'b1;
            busy_q     <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.mem_done) begin
            if (!we_q) begin
              if (owner_q) begin
                d_rdata_q <= bus.mem_rdata;
              end else begin
                i_rdata_q <= bus.mem_rdata;
              end
            end
            if (owner_q) begin
              d_done_q <= 1'b1;
            end else begin
              i_done_q <= 1'b1;
            end
            mem_req_q <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q    <= 1'b0;
          mem_req_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Drive the bus and status ports straight from the registers.
  assign bus.i_done    = i_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign arb_busy      = busy_q;
  assign arb_owner     = owner_q;

endmodule
